// File: rtl/issue_scoreboard.sv
// Issue controller: decodes each instruction, tracks in-flight register writes in a
// writeback reservation pipeline, stalls on RAW/WAW/write-port hazards and sequences wb_*.
module issue_scoreboard #(
   parameter int ALU_LAT = 3,
   parameter int MEM_LAT = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   output logic        issue_fire,
   output logic        wb_en,
   output logic [2:0]  wb_addr,
   output logic        wb_is_mem,
   output logic [7:0]  busy_mask
);

   localparam logic [4:0] OP_LDM = 5'b00001;
   localparam logic [4:0] OP_STD = 5'b00010;
   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_NOT = 5'b00100;

   typedef struct packed {
      logic       valid;
      logic [2:0] addr;
      logic       is_mem;
   } slot_t;

   localparam slot_t SLOT_EMPTY = slot_t'(5'd0);

   slot_t       slot_r     [MEM_LAT];
   slot_t       slot_nxt_s [MEM_LAT];
   logic [7:0]  busy_mask_r;
   logic [7:0]  busy_nxt_s;

   logic [2:0]  field_a_s;
   logic [2:0]  field_b_s;
   logic [2:0]  dest_s;
   logic        use_a_s;
   logic        use_b_s;
   logic        is_alu_s;
   logic        is_ldm_s;
   logic        raw_s;
   logic        waw_s;
   logic        port_s;
   logic        unused_s;

   assign field_a_s = instr[26:24];
   assign field_b_s = instr[23:21];
   assign unused_s  = ^instr[20:0];

   // Opcode decode into source usage, writer class and destination register.
   always_comb begin
      use_a_s  = 1'b0;
      use_b_s  = 1'b0;
      is_alu_s = 1'b0;
      is_ldm_s = 1'b0;
      dest_s   = 3'd0;
      case (instr[31:27])
         OP_LDM: begin
            is_ldm_s = 1'b1;
            dest_s   = field_a_s;
         end
         OP_STD: begin
            use_a_s = 1'b1;
            use_b_s = 1'b1;
         end
         OP_ADD: begin
            use_a_s  = 1'b1;
            use_b_s  = 1'b1;
            is_alu_s = 1'b1;
            dest_s   = field_b_s;
         end
         OP_NOT: begin
            use_a_s  = 1'b1;
            is_alu_s = 1'b1;
            dest_s   = field_b_s;
         end
         default: begin
         end
      endcase
   end

   // An ALU writer would land in the slot that s[ALU_LAT] shifts into, sharing its writeback cycle.
   assign raw_s  = (use_a_s & busy_mask_r[field_a_s]) | (use_b_s & busy_mask_r[field_b_s]);
   assign waw_s  = (is_alu_s | is_ldm_s) & busy_mask_r[dest_s];
   assign port_s = is_alu_s & slot_r[ALU_LAT].valid;

   assign instr_ready = ~(raw_s | waw_s | port_s);
   assign issue_fire  = instr_valid & instr_ready;

   // Reservation pipeline next state: shift toward s[0], insert overrides the shift.
   always_comb begin
      for (int k = 0; k < MEM_LAT - 1; k++) begin
         slot_nxt_s[k] = slot_r[k + 1];
      end
      slot_nxt_s[MEM_LAT-1] = SLOT_EMPTY;
      if (issue_fire && is_alu_s) begin
         slot_nxt_s[ALU_LAT-1] = '{valid: 1'b1, addr: dest_s, is_mem: 1'b0};
      end else if (issue_fire && is_ldm_s) begin
         slot_nxt_s[MEM_LAT-1] = '{valid: 1'b1, addr: dest_s, is_mem: 1'b1};
      end else begin
         slot_nxt_s[MEM_LAT-1] = SLOT_EMPTY;
      end
   end

   // Busy mask of the next pipeline contents, so the register always matches the slots.
   always_comb begin
      busy_nxt_s = 8'd0;
      for (int k = 0; k < MEM_LAT; k++) begin
         busy_nxt_s = busy_nxt_s | (8'(slot_nxt_s[k].valid) << slot_nxt_s[k].addr);
      end
   end

   // Pipeline and busy-mask state; reset discards every pending writeback.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < MEM_LAT; k++) begin
            slot_r[k] <= SLOT_EMPTY;
         end
         busy_mask_r <= 8'd0;
      end else begin
         for (int k = 0; k < MEM_LAT; k++) begin
            slot_r[k] <= slot_nxt_s[k];
         end
         busy_mask_r <= busy_nxt_s;
      end
   end

   // Empty slots are all-zero, so wb_addr reads 0 whenever wb_en is low.
   assign wb_en     = slot_r[0].valid;
   assign wb_addr   = slot_r[0].addr;
   assign wb_is_mem = slot_r[0].is_mem;
   assign busy_mask = busy_mask_r;

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Issue controller between fetch and the decode/register-file stage. Decodes the opcode and register fields of each incoming 32-bit instruction and tracks every in-flight register write in a writeback reservation pipeline. It holds back any instruction with a read-after-write hazard, a write-after-write hazard, or a collision on the single register-file write port. It also drives the register-file write-port sequencing (`wb_en`/`wb_addr`) for every issued writer.

## Interface
- `ALU_LAT`, default 3: cycles from issue to writeback for ADD/NOT.
- `MEM_LAT`, default 4: cycles from issue to writeback for LDM. Legal range 1 <= ALU_LAT < MEM_LAT <= 8.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  fetch presents an instruction.
- `instr`  in  32  instruction word:
  - [31:27] opcode
  - [26:24] field A
  - [23:21] field B
- `instr_ready`  out  1  combinational; instruction may issue this cycle.
- `issue_fire`  out  1  combinational; `instr_valid & instr_ready`.
- `wb_en`  out  1  registered; register-file write occurs this cycle.
- `wb_addr`  out  3  registered; register written when `wb_en`=1, else 0.
- `wb_is_mem`  out  1  registered; the current writeback is an LDM result (mem-to-reg select).
- `busy_mask`  out  8  registered; bit r=1 while register r has a pending write.

## Operation
- Opcode classes:

| Opcode | Mnemonic | Sources | Destination | Latency |
|---|---|---|---|---|
| 00001 | LDM | none | A | MEM_LAT |
| 00010 | STD | A, B | none | — |
| 00011 | ADD | A, B | B | ALU_LAT |
| 00100 | NOT | A | B | ALU_LAT |
| 00101 | NOP | none | none | — |
| any other | treated as NOP | none | none | — |

- Reservation pipeline: entries s[0..MEM_LAT-1], each holding {valid, addr[2:0], is_mem}.
- Every edge: s[k] <= s[k+1]; s[MEM_LAT-1] <= empty.
- On `issue_fire` with a destination, the entry {1, dest, is_mem} is written into s[LAT-1]. This insert overrides the shift into that slot.
- `wb_en`/`wb_addr`/`wb_is_mem` are driven directly from s[0].
- `busy_mask` bit r is the OR over all valid entries whose addr = r, including s[0]. There is no bypass: a register is readable only the cycle after its writeback cycle.
- `instr_ready` = 0 if any of the following holds, else 1:
  - RAW: any source register has its busy bit set.
  - WAW: the destination register has its busy bit set.
  - Port conflict: the instruction is a writer with LAT < MEM_LAT and s[LAT].valid = 1.
- `instr_ready` is evaluated regardless of `instr_valid`. With `instr_valid`=0 nothing is inserted.
- Non-writers (STD/NOP/unknown) stall only on RAW.
- Fetch must hold `instr` stable while `instr_valid`=1 and `instr_ready`=0.

## Timing
- Reset (async assert): all entries cleared.
  - `wb_en`=0, `wb_addr`=0, `wb_is_mem`=0, `busy_mask`=0.
  - `instr_ready` resolves to 1 and `issue_fire` follows `instr_valid`.
- Reset asserted mid-operation discards all pending writebacks immediately; no `wb_en` pulse is produced for them.
- Issue at edge T (fire high in cycle T): `wb_en`=1 in cycle T+LAT, and `busy_mask` bit set from cycle T+1 through T+LAT inclusive.
- A dependent instruction fires no earlier than cycle T+LAT+1.
- Throughput is one instruction per cycle when hazard-free.
- At most one `wb_en` per cycle, guaranteed by the port check.
- Simultaneous insert and shift-out in the same edge is legal; both take effect.

## Test plan
- **RAW stall, defaults.** Cycle 0: ADD A=1,B=2. Cycle 1: ADD A=2,B=3 held valid.
  - `instr_ready`=0 in cycles 1-3.
  - `wb_en`=1 with `wb_addr`=2 in cycle 3.
  - Second instruction fires in cycle 4; its `wb_en` with `wb_addr`=3 occurs in cycle 7.
- **Port conflict.** Cycle 0: LDM A=5. Cycle 1: ADD A=0,B=1 (independent).
  - Stalled in cycle 1, fires in cycle 2.
  - `wb_en` with addr 5 and `wb_is_mem`=1 in cycle 4; `wb_en` with addr 1 and `wb_is_mem`=0 in cycle 5.
- **WAW.** Cycle 0: LDM A=4. Cycle 1: NOT A=0,B=4.
  - Stalled through cycle 4, fires in cycle 5.
  - `wb_addr`=4 appears in cycles 4 and 8, in that order.
- **Back-to-back independent issue.** ADD B=1, B=2, B=3 in cycles 0-2.
  - No stalls.
  - `wb_en` in cycles 3-4-5 with addrs 1-2-3.
  - `busy_mask`=8'b00001110 in cycle 3.
- **Non-writers and reset.**
  - STD A=6,B=7 and NOP with an empty scoreboard: fire immediately; `busy_mask` stays 0; no `wb_en`.
  - Pull `reset_n` low in cycle 2 after LDM A=5: `busy_mask`=0 immediately; no `wb_en` follows; the next instruction fires on the first cycle after release.
